mutex_arbiter: RTL and testbench

- Two-requester mutual-exclusion arbiter: the granting end of the req/grant four-phase handshake.
- Each requester raises `req`, holds it until its `grant` is seen, then drops it. The arbiter drops `grant` once it sees `req` low.
- The block guarantees `grant0 & grant1 == 0` in every cycle, resolves simultaneous requests, and revokes grants that are held too long.
- It sits between the request generators and the shared resource.

---
 rtl/mutex_arbiter.sv | 141 ++++++++++++++
 tb/tb_mutex_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mutex_arbiter.sv
// ============================================================================
// Module      : mutex_arbiter
// Description : Two-requester mutual-exclusion arbiter (granting end of a
//               four-phase req/grant handshake) with request synchronizers,
//               tie resolution and hold-time revocation.
//               Optional macro MUTEX_ROUND_ROBIN_EN selects round-robin ties;
//               otherwise channel 0 wins every tie.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mutex_arbiter #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_HOLD    = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic grant0,
    output logic grant1,
    output logic busy,
    output logic timeout
);

    localparam logic [15:0] c_HOLD_LAST  = 16'(MAX_HOLD - 1);
    localparam bit          c_TIMEOUT_EN = (MAX_HOLD != 0);

    // One-hot-or-zero encoding: bit 0 = grant0, bit 1 = grant1, bit 2 = timeout.
    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_G0     = 3'b001,
        S_G1     = 3'b010,
        S_REVOKE = 3'b100
    } state_e;

    state_e      state_q;
    logic [1:0]  mask_q;
    logic        last_q;
    logic [15:0] hold_cnt_q;

    logic        req0_s;
    logic        req1_s;
    logic [1:0]  w_elig;
    logic        w_tie_pick0;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0][1:0] sync_q;

            for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_stage
                if (i == 0) begin : g_head
                    always_ff @(posedge clk or negedge reset) begin
                        if (!reset) sync_q[i] <= 2'b00;
                        else        sync_q[i] <= {req1, req0};
                    end
                end else begin : g_tail
                    always_ff @(posedge clk or negedge reset) begin
                        if (!reset) sync_q[i] <= 2'b00;
                        else        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign {req1_s, req0_s} = sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign req0_s = req0;
            assign req1_s = req1;
        end
    endgenerate

    assign w_elig = {req1_s & ~mask_q[1], req0_s & ~mask_q[0]};

`ifdef MUTEX_ROUND_ROBIN_EN
    assign w_tie_pick0 = last_q;
`else
    // last is kept current in both builds; fixed priority ignores its value.
    assign w_tie_pick0 = last_q | 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mask_q     <= 2'b00;
            last_q     <= 1'b1;
            hold_cnt_q <= 16'd0;
        end else begin
            if (!req0_s) mask_q[0] <= 1'b0;
            if (!req1_s) mask_q[1] <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    hold_cnt_q <= 16'd0;
                    if (w_elig[0] && (!w_elig[1] || w_tie_pick0)) begin
                        state_q <= S_G0;
                        last_q  <= 1'b0;
                    end else if (w_elig[1]) begin
                        state_q <= S_G1;
                        last_q  <= 1'b1;
                    end
                end
                S_G0: begin
                    if (!req0_s) begin
                        state_q <= S_IDLE;
                    end else if (c_TIMEOUT_EN && (hold_cnt_q == c_HOLD_LAST)) begin
                        state_q   <= S_REVOKE;
                        mask_q[0] <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 16'd1;
                    end
                end
                S_G1: begin
                    if (!req1_s) begin
                        state_q <= S_IDLE;
                    end else if (c_TIMEOUT_EN && (hold_cnt_q == c_HOLD_LAST)) begin
                        state_q   <= S_REVOKE;
                        mask_q[1] <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 16'd1;
                    end
                end
                S_REVOKE: begin
                    state_q    <= S_IDLE;
                    hold_cnt_q <= 16'd0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    hold_cnt_q <= 16'd0;
                end
            endcase
        end
    end

    assign grant0  = state_q[0];
    assign grant1  = state_q[1];
    assign timeout = state_q[2];
    assign busy    = state_q[0] | state_q[1];

endmodule

`default_nettype wire

// File: tb/tb_mutex_arbiter.sv
// ============================================================================
// Module      : tb_mutex_arbiter
// Description : Self-checking bench for mutex_arbiter; three configurations
//               compared every cycle against a behavioural ownership model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mutex_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic ra0, ra1, ga0, ga1, ba, ta;
    logic rb0, rb1, gb0, gb1, bb, tb;
    logic rc0, rc1, gc0, gc1, bc, tc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mutex_arbiter #(.SYNC_STAGES(0), .MAX_HOLD(4)) dut_a (
        .clk(clk), .reset(reset), .req0(ra0), .req1(ra1),
        .grant0(ga0), .grant1(ga1), .busy(ba), .timeout(ta));

    mutex_arbiter #(.SYNC_STAGES(2), .MAX_HOLD(64)) dut_b (
        .clk(clk), .reset(reset), .req0(rb0), .req1(rb1),
        .grant0(gb0), .grant1(gb1), .busy(bb), .timeout(tb));

    mutex_arbiter #(.SYNC_STAGES(0), .MAX_HOLD(0)) dut_c (
        .clk(clk), .reset(reset), .req0(rc0), .req1(rc1),
        .grant0(gc0), .grant1(gc1), .busy(bc), .timeout(tc));

    // owner: -1 none, else channel; held: cycles granted so far.
    typedef struct packed {
        int         owner;
        int         held;
        int         last;
        logic       tmo;
        logic [1:0] blk;
    } model_t;

    model_t     ma, mb, mc;
    logic [1:0] pb0, pb1;

    function automatic model_t model_reset();
        model_t m;
        m.owner = -1; m.held = 0; m.last = 1; m.tmo = 1'b0; m.blk = 2'b00;
        return m;
    endfunction

    function automatic model_t step(input model_t m, input logic r0, input logic r1, input int hold);
        model_t     n;
        logic [1:0] r;
        logic       e0, e1;
        int         pick;
        n = m;
        r = {r1, r0};
        if (m.tmo) begin
            n.tmo = 1'b0;
        end else if (m.owner >= 0) begin
            if (!r[m.owner]) n.owner = -1;
            else if (hold != 0 && m.held == hold) begin
                n.owner = -1; n.tmo = 1'b1; n.blk[m.owner] = 1'b1;
            end else n.held = m.held + 1;
        end else begin
            e0 = r[0] && !m.blk[0];
            e1 = r[1] && !m.blk[1];
            pick = -1;
            if (e0 && e1) begin
`ifdef MUTEX_ROUND_ROBIN_EN
                pick = (m.last == 0) ? 1 : 0;
`else
                pick = 0;
`endif
            end else if (e0) pick = 0;
            else if (e1) pick = 1;
            if (pick >= 0) begin
                n.owner = pick; n.held = 1; n.last = pick;
            end
        end
        for (int x = 0; x < 2; x++) if (!r[x]) n.blk[x] = 1'b0;
        return n;
    endfunction

    function automatic logic [3:0] expv(input model_t m);
        return {m.tmo, m.owner == 1, m.owner == 0, m.owner >= 0};
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic models_reset();
        ma = model_reset(); mb = model_reset(); mc = model_reset();
        pb0 = 2'b00; pb1 = 2'b00;
    endtask

    // Advance one edge, update models, compare; returns at the next negedge.
    task automatic tick();
        @(posedge clk);
        ma  = step(ma, ra0, ra1, 4);
        mb  = step(mb, pb1[0], pb1[1], 64);
        pb1 = pb0;
        pb0 = {rb1, rb0};
        mc  = step(mc, rc0, rc1, 0);
        #1;
        chk("model_a", {ta, ga1, ga0, ba}, expv(ma));
        chk("model_b", {tb, gb1, gb0, bb}, expv(mb));
        chk("model_c", {tc, gc1, gc0, bc}, expv(mc));
        chk("excl", {1'b0, ga0 & ga1, gb0 & gb1, gc0 & gc1}, 4'b0000);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        models_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int         seq[$];
        int         g1_cycles, rises0, rises1, dur0, dur1;
        logic       p0, p1;
        logic [3:0] pat;

        reset = 1'b0;
        {ra0, ra1, rb0, rb1, rc0, rc1} = '0;
        models_reset();
        @(negedge clk);
        #1;
        chk("rst_a", {ta, ga1, ga0, ba}, 4'b0000);
        chk("rst_b", {tb, gb1, gb0, bb}, 4'b0000);
        chk("rst_c", {tc, gc1, gc0, bc}, 4'b0000);
        @(negedge clk);
        reset = 1'b1;

        // Single request, no timeout configured.
        rc0 = 1'b1;
        tick();
        chk("c_grant0", {tc, gc1, gc0, bc}, 4'b0011);
        repeat (9) tick();
        chk("c_hold_notimeout", {tc, gc1, gc0, bc}, 4'b0011);
        rc0 = 1'b0;
        tick();
        chk("c_release", {tc, gc1, gc0, bc}, 4'b0000);

        // Both requesters handshaking continuously from reset.
        do_reset();
        rc0 = 1'b1; rc1 = 1'b1;
        p0 = 1'b0; p1 = 1'b0; g1_cycles = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (gc0 && !p0) seq.push_back(0);
            if (gc1 && !p1) seq.push_back(1);
            if (gc1) g1_cycles++;
            p0 = gc0; p1 = gc1;
            if (rc0 && gc0) rc0 = 1'b0; else if (!rc0 && !gc0) rc0 = 1'b1;
            if (rc1 && gc1) rc1 = 1'b0; else if (!rc1 && !gc1) rc1 = 1'b1;
        end
        chk_int("c_nrises", int'(seq.size() >= 4), 1);
        pat = 4'b0000;
        for (int i = 0; i < 4 && i < seq.size(); i++) pat[i] = (seq[i] == 1);
`ifdef MUTEX_ROUND_ROBIN_EN
        chk("c_order_rr", pat, 4'b1010);
        chk_int("c_g1_served", int'(g1_cycles > 0), 1);
`else
        chk("c_order_fixed", pat, 4'b0000);
        chk_int("c_g1_cycles", g1_cycles, 0);
`endif
        rc0 = 1'b0; rc1 = 1'b0;
        repeat (2) tick();

        // Timeout on channel 0 with channel 1 waiting.
        ra0 = 1'b1; ra1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("a_hold", {ta, ga1, ga0, ba}, 4'b0011);
        end
        tick();
        chk("a_timeout", {ta, ga1, ga0, ba}, 4'b1000);
        tick();
        chk("a_idle_after", {ta, ga1, ga0, ba}, 4'b0000);
        tick();
        chk("a_grant1", {ta, ga1, ga0, ba}, 4'b0101);
        ra1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("a_masked", {ta, ga1, ga0, ba}, 4'b0000);
        end
        ra0 = 1'b0;
        tick();
        ra0 = 1'b1;
        tick();
        chk("a_regrant", {ta, ga1, ga0, ba}, 4'b0011);
        ra0 = 1'b0;
        tick();

        // Synchronizer latency with negedge-driven request.
        rb1 = 1'b1;
        tick();
        chk("b_lat0", {tb, gb1, gb0, bb}, 4'b0000);
        tick();
        chk("b_lat1", {tb, gb1, gb0, bb}, 4'b0000);
        tick();
        chk("b_lat2", {tb, gb1, gb0, bb}, 4'b0101);

        // Long run: handshakes on B, random request streams on A.
        rises0 = 0; rises1 = 0; p0 = gb0; p1 = gb1;
        dur0 = 1; dur1 = 1;
        for (int k = 0; k < 1000; k++) begin
            if (rb0 && gb0) rb0 = 1'b0; else if (!rb0 && !gb0) rb0 = 1'b1;
            if (rb1 && gb1) rb1 = 1'b0; else if (!rb1 && !gb1) rb1 = 1'b1;
            dur0--; dur1--;
            if (dur0 == 0) begin ra0 = ~ra0; dur0 = $urandom_range(1, 9); end
            if (dur1 == 0) begin ra1 = ~ra1; dur1 = $urandom_range(1, 9); end
            tick();
            if (gb0 && !p0) rises0++;
            if (gb1 && !p1) rises1++;
            p0 = gb0; p1 = gb1;
        end
        chk_int("b_live0", int'(rises0 > 0), 1);
        chk_int("b_live1", int'(rises1 > 0), 1);
        chk_int("b_progress", int'(rises0 + rises1 > 50), 1);
        {ra0, ra1, rb0, rb1} = '0;
        repeat (4) tick();

        // Asynchronous reset while grant1 is held.
        rc1 = 1'b1;
        tick();
        chk("c_g1_before_rst", {tc, gc1, gc0, bc}, 4'b0101);
        #2;
        reset = 1'b0;
        models_reset();
        #1;
        chk("c_rst_async", {tc, gc1, gc0, bc}, 4'b0000);
        rc0 = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("c_rst_tie", {tc, gc1, gc0, bc}, 4'b0011);
        {rc0, rc1} = '0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
